// File: rtl/sprite_line_scheduler_pkg.sv
// ============================================================================
// Module      : sprite_pkg
// Description : Shared constants, enums, row type and the ROM column mapping
//               helper for the sprite line scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

    localparam int SPR_W = 18;
    localparam int SPR_H = 25;
    localparam int IDX_W = 4;
    localparam int COL_W = 5;

    typedef enum logic {
        SPR_BLUE = 1'b0,
        SPR_RED  = 1'b1
    } spr_id_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        FETCH_B = 3'd2,
        DRAIN_B = 3'd3,
        FETCH_R = 3'd4,
        DRAIN_R = 3'd5
    } fetch_state_t;

    typedef logic [0:SPR_W-1][IDX_W-1:0] spr_row_t;

    // ROM column for a buffer column; a flipped sprite is read right-to-left
    function automatic logic [COL_W-1:0] map_col(input logic [COL_W-1:0] col,
                                                 input logic             flip);
        return flip ? (COL_W'(SPR_W - 1) - col) : col;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_line_scheduler_if.sv
// ============================================================================
// Module      : sprite_line_scheduler_if
// Description : Sprite-ROM read port. Master issues row/col requests, slave
//               returns the palette index one cycle after each request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sprite_line_scheduler_if;
    import sprite_pkg::*;

    logic                 rom_req;
    logic                 rom_sel;
    logic [COL_W-1:0]     rom_row;
    logic [COL_W-1:0]     rom_col;
    logic [IDX_W-1:0]     rom_data;

    modport master (output rom_req, rom_sel, rom_row, rom_col, input rom_data);
    modport slave  (input rom_req, rom_sel, rom_row, rom_col, output rom_data);
endinterface

`default_nettype wire

// File: rtl/sprite_line_scheduler_row_buffer.sv
// ============================================================================
// Module      : sprite_row_buffer
// Description : Double-buffered row store for one sprite: two banks, valid
//               flags, latched x per bank, bank toggle, write port into the
//               back bank and combinational candidate lookup on the front.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_row_buffer
    import sprite_pkg::*;
#(
    parameter int X_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             swap,
    input  logic             abort,
    input  logic [X_W-1:0]   new_x,
    input  logic             wr_en,
    input  logic             wr_last,
    input  logic [COL_W-1:0] wr_col,
    input  logic [IDX_W-1:0] wr_data,
    input  logic [X_W-1:0]   draw_x,
    output logic             cand,
    output logic [IDX_W-1:0] cand_idx
);

    spr_row_t          r_bank [2];
    logic [X_W-1:0]    r_x    [2];
    logic [1:0]        r_valid;
    logic              r_front;

    logic              w_back;
    logic [X_W-1:0]    w_dx;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;

    assign w_back = ~r_front;

    // Pixel storage and latched x need no reset; only valid gates their use
    always_ff @(posedge clk) begin
        if (swap) begin
            r_x[r_front] <= new_x;
        end
        if (wr_en) begin
            r_bank[w_back][wr_col] <= wr_data;
        end
    end

    // Bank toggle and valid flags; the incoming back bank is invalid until refilled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_front <= 1'b0;
            r_valid <= 2'b00;
        end else if (swap) begin
            r_front          <= ~r_front;
            r_valid[r_front] <= 1'b0;
            if (abort) begin
                r_valid[w_back] <= 1'b0;
            end
        end else if (wr_en && wr_last) begin
            r_valid[w_back] <= 1'b1;
        end
    end

    // Front-bank lookup; an unsigned wrap of dx lands far out of range
    always_comb begin
        w_dx       = draw_x - r_x[r_front];
        w_in_range = (w_dx < X_W'(SPR_W));
        w_idx      = w_in_range ? r_bank[r_front][w_dx[COL_W-1:0]] : '0;
        cand       = r_valid[r_front] && w_in_range && (w_idx != '0);
        cand_idx   = w_idx;
    end

endmodule

`default_nettype wire

// File: rtl/sprite_line_scheduler.sv
// ============================================================================
// Module      : sprite_line_scheduler
// Description : Per-scanline fetch scheduler for the blue and red tank
//               sprites. Arbitrates the shared sprite ROM during hblank and
//               serves a registered, red-over-blue pixel index in active video.
//               Optional macro SPRITE_FLIP_EN adds per-sprite horizontal flip.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_line_scheduler
    import sprite_pkg::*;
#(
    parameter int X_W = 10,
    parameter int Y_W = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     line_start,
    input  logic [Y_W-1:0]           next_y,
    input  logic [X_W-1:0]           blue_x,
    input  logic [X_W-1:0]           red_x,
    input  logic [Y_W-1:0]           blue_y,
    input  logic [Y_W-1:0]           red_y,
`ifdef SPRITE_FLIP_EN
    input  logic                     blue_flip,
    input  logic                     red_flip,
`endif
    sprite_line_scheduler_if.master  rom,
    input  logic [X_W-1:0]           draw_x,
    output logic                     pix_hit,
    output logic                     pix_sel,
    output logic [IDX_W-1:0]         pix_idx,
    output logic                     busy
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPR_W - 1);

    fetch_state_t      r_state;
    logic [Y_W-1:0]    r_ny;
    logic [COL_W-1:0]  r_col;
    logic [COL_W-1:0]  r_row_r;
    logic              r_hit_b;
    logic              r_hit_r;
    logic              r_rom_req;
    logic              r_rom_sel;
    logic [COL_W-1:0]  r_rom_row;
    logic [COL_W-1:0]  r_rom_col;
    logic              r_ret_vld;
    logic              r_ret_sel;
    logic [COL_W-1:0]  r_ret_col;

    logic [Y_W-1:0]    w_row_b;
    logic [Y_W-1:0]    w_row_r;
    logic              w_hit_b;
    logic              w_hit_r;
    logic              w_flip_b;
    logic              w_flip_r;
    logic              w_abort;
    logic              w_wr;
    logic              w_wr_last;
    logic              w_cand_b;
    logic              w_cand_r;
    logic [IDX_W-1:0]  w_idx_b;
    logic [IDX_W-1:0]  w_idx_r;

`ifdef SPRITE_FLIP_EN
    logic              r_flip_b;
    logic              r_flip_r;

    // Flip settings are held for the whole line being fetched
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flip_b <= 1'b0;
            r_flip_r <= 1'b0;
        end else if (line_start) begin
            r_flip_b <= blue_flip;
            r_flip_r <= red_flip;
        end
    end

    assign w_flip_b = r_flip_b;
    assign w_flip_r = r_flip_r;
`else
    assign w_flip_b = 1'b0;
    assign w_flip_r = 1'b0;
`endif

    // Row offsets wrap when the tank sits below the line, so one compare suffices
    assign w_row_b = r_ny - blue_y;
    assign w_row_r = r_ny - red_y;
    assign w_hit_b = (w_row_b < Y_W'(SPR_H));
    assign w_hit_r = (w_row_r < Y_W'(SPR_H));

    // A new line request always wins over a return still in flight
    assign w_abort   = line_start && (r_state != IDLE);
    assign w_wr      = r_ret_vld && !line_start;
    assign w_wr_last = (r_ret_col == COL_LAST);
    assign busy      = (r_state != IDLE);

    assign rom.rom_req = r_rom_req;
    assign rom.rom_sel = r_rom_sel;
    assign rom.rom_row = r_rom_row;
    assign rom.rom_col = r_rom_col;

    // Fetch FSM with registered ROM strobes and a one-cycle return tracker
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_ny      <= '0;
            r_col     <= '0;
            r_row_r   <= '0;
            r_hit_b   <= 1'b0;
            r_hit_r   <= 1'b0;
            r_rom_req <= 1'b0;
            r_rom_sel <= SPR_BLUE;
            r_rom_row <= '0;
            r_rom_col <= '0;
            r_ret_vld <= 1'b0;
            r_ret_sel <= SPR_BLUE;
            r_ret_col <= '0;
        end else begin
            r_ret_vld <= r_rom_req && !line_start;
            r_ret_sel <= r_rom_sel;
            r_ret_col <= r_col;
            if (line_start) begin
                r_state   <= CHECK;
                r_ny      <= next_y;
                r_rom_req <= 1'b0;
                r_col     <= '0;
            end else begin
                case (r_state)
                    CHECK: begin
                        r_hit_b   <= w_hit_b;
                        r_hit_r   <= w_hit_r;
                        r_row_r   <= w_row_r[COL_W-1:0];
                        r_state   <= FETCH_B;
                        r_rom_req <= w_hit_b;
                        r_rom_sel <= SPR_BLUE;
                        r_rom_row <= w_row_b[COL_W-1:0];
                        r_col     <= '0;
                        r_rom_col <= map_col('0, w_flip_b);
                    end
                    FETCH_B: begin
                        if (r_hit_b && (r_col != COL_LAST)) begin
                            r_col     <= r_col + 1'b1;
                            r_rom_col <= map_col(r_col + 1'b1, w_flip_b);
                        end else if (r_hit_b) begin
                            r_rom_req <= 1'b0;
                            r_state   <= DRAIN_B;
                        end else begin
                            r_state   <= FETCH_R;
                            r_rom_req <= r_hit_r;
                            r_rom_sel <= SPR_RED;
                            r_rom_row <= r_row_r;
                            r_col     <= '0;
                            r_rom_col <= map_col('0, w_flip_r);
                        end
                    end
                    DRAIN_B: begin
                        r_state   <= FETCH_R;
                        r_rom_req <= r_hit_r;
                        r_rom_sel <= SPR_RED;
                        r_rom_row <= r_row_r;
                        r_col     <= '0;
                        r_rom_col <= map_col('0, w_flip_r);
                    end
                    FETCH_R: begin
                        if (r_hit_r && (r_col != COL_LAST)) begin
                            r_col     <= r_col + 1'b1;
                            r_rom_col <= map_col(r_col + 1'b1, w_flip_r);
                        end else if (r_hit_r) begin
                            r_rom_req <= 1'b0;
                            r_state   <= DRAIN_R;
                        end else begin
                            r_state   <= IDLE;
                        end
                    end
                    DRAIN_R: r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    sprite_row_buffer #(.X_W(X_W)) u_blue (
        .clk      (clk),
        .reset_n  (reset_n),
        .swap     (line_start),
        .abort    (w_abort),
        .new_x    (blue_x),
        .wr_en    (w_wr && (r_ret_sel == SPR_BLUE)),
        .wr_last  (w_wr_last),
        .wr_col   (r_ret_col),
        .wr_data  (rom.rom_data),
        .draw_x   (draw_x),
        .cand     (w_cand_b),
        .cand_idx (w_idx_b)
    );

    sprite_row_buffer #(.X_W(X_W)) u_red (
        .clk      (clk),
        .reset_n  (reset_n),
        .swap     (line_start),
        .abort    (w_abort),
        .new_x    (red_x),
        .wr_en    (w_wr && (r_ret_sel == SPR_RED)),
        .wr_last  (w_wr_last),
        .wr_col   (r_ret_col),
        .wr_data  (rom.rom_data),
        .draw_x   (draw_x),
        .cand     (w_cand_r),
        .cand_idx (w_idx_r)
    );

    // Registered pixel output; red is drawn on top of blue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_hit <= 1'b0;
            pix_sel <= SPR_BLUE;
            pix_idx <= '0;
        end else if (w_cand_r) begin
            pix_hit <= 1'b1;
            pix_sel <= SPR_RED;
            pix_idx <= w_idx_r;
        end else if (w_cand_b) begin
            pix_hit <= 1'b1;
            pix_sel <= SPR_BLUE;
            pix_idx <= w_idx_b;
        end else begin
            pix_hit <= 1'b0;
            pix_sel <= SPR_BLUE;
            pix_idx <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sprite_line_scheduler.sv
// ============================================================================
// Module      : tb_sprite_line_scheduler
// Description : Directed self-checking bench for sprite_line_scheduler with a
//               one-cycle-latency ROM model (content f(sel,row,col)).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_line_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  next_y = '0;
    logic [9:0]  blue_x = '0, red_x = '0, blue_y = '0, red_y = '0;
    logic [9:0]  draw_x = '0;
    logic        blue_flip = 1'b0, red_flip = 1'b0;
    logic        pix_hit, pix_sel, busy;
    logic [3:0]  pix_idx;
    logic        red_zero = 1'b0;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [10:0] reqs [$];

    sprite_line_scheduler_if rom_bus ();

    sprite_line_scheduler #(.X_W(10), .Y_W(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .line_start (line_start),
        .next_y     (next_y),
        .blue_x     (blue_x),
        .red_x      (red_x),
        .blue_y     (blue_y),
        .red_y      (red_y),
`ifdef SPRITE_FLIP_EN
        .blue_flip  (blue_flip),
        .red_flip   (red_flip),
`endif
        .rom        (rom_bus.master),
        .draw_x     (draw_x),
        .pix_hit    (pix_hit),
        .pix_sel    (pix_sel),
        .pix_idx    (pix_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ROM content: nonzero everywhere except red column 2 when red_zero is set
    function automatic logic [3:0] rom_fn(input logic sel, input logic [4:0] row, input logic [4:0] col);
        int v;
        if (sel && red_zero && (col == 5'd2)) return 4'd0;
        v = ((int'(row) * 3 + int'(col) * 5 + int'(sel) * 7) % 15) + 1;
        return 4'(v);
    endfunction

    initial rom_bus.rom_data = '0;
    always @(posedge clk)
        rom_bus.rom_data <= rom_bus.rom_req ? rom_fn(rom_bus.rom_sel, rom_bus.rom_row, rom_bus.rom_col) : 4'd0;

    always @(negedge clk)
        if (rom_bus.rom_req === 1'b1)
            reqs.push_back({rom_bus.rom_sel, rom_bus.rom_row, rom_bus.rom_col});

    // Pulse line_start for one cycle; returns on the CHECK cycle
    task automatic start_line(input logic [9:0] y);
        @(negedge clk);
        next_y = y;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        reqs.delete();
    endtask

    // Count busy cycles from the CHECK cycle on, bounded
    task automatic wait_idle(output int cnt);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic sample_pix(input logic [9:0] x, output logic [5:0] obs);
        @(negedge clk);
        draw_x = x;
        @(negedge clk);
        obs = {pix_hit, pix_sel, pix_idx};
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        logic [23:0] outs;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        outs = {busy, rom_bus.rom_req, rom_bus.rom_sel, rom_bus.rom_row, rom_bus.rom_col, pix_hit, pix_sel, pix_idx};
        n_checks++; if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs); else n_pass++;
        reset_n = 1'b1;
        blue_x = 10'd100; blue_y = 10'd200; red_x = 10'd400; red_y = 10'd400;
        start_line(10'd203);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        outs = {busy, rom_bus.rom_req, rom_bus.rom_sel, rom_bus.rom_row, rom_bus.rom_col, pix_hit, pix_sel, pix_idx};
        n_checks++; if (outs !== '0) $display("FAIL reset_mid_fetch: got %h want 0", outs); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        sample_pix(10'd108, obs);
        n_checks++; if (obs !== 6'd0) $display("FAIL reset_pix_108: got %h want 00", obs); else n_pass++;
        sample_pix(10'd100, obs);
        n_checks++; if (obs !== 6'd0) $display("FAIL reset_pix_100: got %h want 00", obs); else n_pass++;
    endtask

    task automatic test_single_hit();
        int cnt;
        logic [5:0] obs;
        blue_x = 10'd100; blue_y = 10'd200; red_x = 10'd400; red_y = 10'd400;
        start_line(10'd203);
        wait_idle(cnt);
        n_checks++; if (cnt !== 21) $display("FAIL single_busy: got %0d want 21", cnt); else n_pass++;
        n_checks++; if (reqs.size() !== 18) $display("FAIL single_req_count: got %0d want 18", reqs.size()); else n_pass++;
        for (int i = 0; i < 18 && i < reqs.size(); i++) begin
            n_checks++;
            if (reqs[i] !== {1'b0, 5'd3, 5'(i)}) $display("FAIL single_req_%0d: got %h want %h", i, reqs[i], {1'b0, 5'd3, 5'(i)});
            else n_pass++;
        end
        start_line(10'd204);
        wait_idle(cnt);
        sample_pix(10'd108, obs);
        n_checks++; if (obs !== {1'b1, 1'b0, 4'd5}) $display("FAIL single_pix_108: got %h want 25", obs); else n_pass++;
        sample_pix(10'd99, obs);
        n_checks++; if (obs !== 6'd0) $display("FAIL single_pix_99: got %h want 00", obs); else n_pass++;
    endtask

    task automatic test_edges();
        int cnt;
        logic [5:0] obs;
        blue_x = 10'd100; blue_y = 10'd10; red_x = 10'd400; red_y = 10'd400;
        start_line(10'd9);
        wait_idle(cnt);
        n_checks++; if (reqs.size() !== 0) $display("FAIL edge_above_reqs: got %0d want 0", reqs.size()); else n_pass++;
        n_checks++; if (cnt !== 3) $display("FAIL edge_above_busy: got %0d want 3", cnt); else n_pass++;
        start_line(10'd34);
        wait_idle(cnt);
        n_checks++; if (reqs.size() !== 18) $display("FAIL edge_row24_count: got %0d want 18", reqs.size()); else n_pass++;
        n_checks++; if (reqs.size() == 0 || reqs[0] !== {1'b0, 5'd24, 5'd0}) $display("FAIL edge_row24_first: got %h want %h", (reqs.size() != 0) ? reqs[0] : 11'h7ff, {1'b0, 5'd24, 5'd0}); else n_pass++;
        start_line(10'd35);
        wait_idle(cnt);
        n_checks++; if (reqs.size() !== 0) $display("FAIL edge_row25_reqs: got %0d want 0", reqs.size()); else n_pass++;
        sample_pix(10'd117, obs);
        n_checks++; if (obs !== {1'b1, 1'b0, 4'd8}) $display("FAIL edge_pix_117: got %h want 28", obs); else n_pass++;
        sample_pix(10'd118, obs);
        n_checks++; if (obs !== 6'd0) $display("FAIL edge_pix_118: got %h want 00", obs); else n_pass++;
        sample_pix(10'd100, obs);
        n_checks++; if (obs !== {1'b1, 1'b0, 4'd13}) $display("FAIL edge_pix_100: got %h want 2d", obs); else n_pass++;
        start_line(10'd36);
        wait_idle(cnt);
        sample_pix(10'd100, obs);
        n_checks++; if (obs !== 6'd0) $display("FAIL edge_skipped_line: got %h want 00", obs); else n_pass++;
    endtask

    task automatic test_overlap();
        int cnt;
        logic [5:0] obs;
        blue_x = 10'd50; blue_y = 10'd60; red_x = 10'd50; red_y = 10'd60;
        red_zero = 1'b0;
        start_line(10'd60);
        wait_idle(cnt);
        n_checks++; if (cnt !== 39) $display("FAIL overlap_busy: got %0d want 39", cnt); else n_pass++;
        n_checks++; if (reqs.size() !== 36) $display("FAIL overlap_req_count: got %0d want 36", reqs.size()); else n_pass++;
        n_checks++; if (reqs.size() < 36 || reqs[18] !== {1'b1, 5'd0, 5'd0} || reqs[35] !== {1'b1, 5'd0, 5'd17})
            $display("FAIL overlap_red_reqs: got %h/%h want 400/411", (reqs.size() > 18) ? reqs[18] : 11'h7ff, (reqs.size() > 35) ? reqs[35] : 11'h7ff);
        else n_pass++;
        start_line(10'd61);
        wait_idle(cnt);
        sample_pix(10'd52, obs);
        n_checks++; if (obs !== {1'b1, 1'b1, 4'd3}) $display("FAIL overlap_red_wins: got %h want 33", obs); else n_pass++;
        red_zero = 1'b1;
        start_line(10'd60);
        wait_idle(cnt);
        start_line(10'd61);
        wait_idle(cnt);
        sample_pix(10'd52, obs);
        n_checks++; if (obs !== {1'b1, 1'b0, 4'd11}) $display("FAIL overlap_red_transparent: got %h want 2b", obs); else n_pass++;
        sample_pix(10'd53, obs);
        n_checks++; if (obs !== {1'b1, 1'b1, 4'd8}) $display("FAIL overlap_red_col3: got %h want 38", obs); else n_pass++;
        red_zero = 1'b0;
    endtask

    task automatic test_abort();
        int cnt;
        logic [5:0] obs;
        blue_x = 10'd100; blue_y = 10'd200; red_x = 10'd400; red_y = 10'd400;
        start_line(10'd203);
        repeat (10) @(negedge clk);
        start_line(10'd205);
        wait_idle(cnt);
        n_checks++; if (cnt !== 21) $display("FAIL abort_busy: got %0d want 21", cnt); else n_pass++;
        n_checks++; if (reqs.size() !== 18) $display("FAIL abort_req_count: got %0d want 18", reqs.size()); else n_pass++;
        n_checks++; if (reqs.size() == 0 || reqs[0] !== {1'b0, 5'd5, 5'd0}) $display("FAIL abort_restart_col0: got %h want 0a0", (reqs.size() != 0) ? reqs[0] : 11'h7ff); else n_pass++;
        sample_pix(10'd105, obs);
        n_checks++; if (obs !== 6'd0) $display("FAIL abort_bank_invalid: got %h want 00", obs); else n_pass++;
        start_line(10'd206);
        wait_idle(cnt);
        sample_pix(10'd105, obs);
        n_checks++; if (obs !== {1'b1, 1'b0, 4'd11}) $display("FAIL abort_refetch_pix: got %h want 2b", obs); else n_pass++;
    endtask

`ifdef SPRITE_FLIP_EN
    task automatic test_flip();
        int cnt;
        logic [5:0] obs;
        blue_x = 10'd100; blue_y = 10'd200; red_x = 10'd400; red_y = 10'd400;
        blue_flip = 1'b1;
        start_line(10'd203);
        wait_idle(cnt);
        n_checks++; if (reqs.size() !== 18 || reqs[0] !== {1'b0, 5'd3, 5'd17} || reqs[17] !== {1'b0, 5'd3, 5'd0})
            $display("FAIL flip_col_order: got %0d reqs first %h want 18 reqs first 071", reqs.size(), (reqs.size() != 0) ? reqs[0] : 11'h7ff);
        else n_pass++;
        start_line(10'd204);
        wait_idle(cnt);
        sample_pix(10'd100, obs);
        n_checks++; if (obs !== {1'b1, 1'b0, 4'd5}) $display("FAIL flip_pix_100: got %h want 25", obs); else n_pass++;
        sample_pix(10'd101, obs);
        n_checks++; if (obs !== {1'b1, 1'b0, 4'd15}) $display("FAIL flip_pix_101: got %h want 2f", obs); else n_pass++;
        blue_flip = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_hit();
        test_edges();
        test_overlap();
        test_abort();
`ifdef SPRITE_FLIP_EN
        test_flip();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline fetch scheduler for the two tank sprites (blue, red), each 25 rows x 18 cols of 4-bit palette indices.
- During horizontal blanking it arbitrates the single shared sprite-ROM read port between the two tanks.
- Fetches each visible tank's row for the next scanline into a double-buffered row store.
- During active video it serves a registered, priority-resolved pixel index to the color mapper.

Parameters:
- SPR_W, 18, sprite width in pixels
- SPR_H, 25, sprite height in rows
- IDX_W, 4, palette index width; index 0 = transparent
- X_W, 10, screen x coordinate width
- Y_W, 10, screen y coordinate width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- line_start  in  1  one-cycle pulse in hblank; requests fetch for next_y and swaps buffers
- next_y  in  Y_W  scanline to be fetched (the line after the one now displaying)
- blue_x, red_x  in  X_W  tank top-left x
- blue_y, red_y  in  Y_W  tank top-left y
- rom_req  out  1  ROM read strobe
- rom_sel  out  1  0 = blue table, 1 = red table
- rom_row  out  5  sprite row, 0..SPR_H-1
- rom_col  out  5  sprite col, 0..SPR_W-1
- rom_data  in  IDX_W  ROM data, valid exactly 1 cycle after rom_req
- draw_x  in  X_W  current active-video pixel x
- pix_hit  out  1  opaque sprite pixel at draw_x (registered)
- pix_sel  out  1  which sprite supplied pix_idx (0 blue, 1 red)
- pix_idx  out  IDX_W  palette index; 0 when pix_hit = 0
- busy  out  1  fetch FSM not in IDLE

Behaviour:
- Reset (async, reset_n = 0): FSM IDLE; all outputs 0; both buffer banks' valid flags cleared. Latched x/y and pixel storage are don't-care.
- line_start:
  - Swap front/back banks.
  - Latch next_y, blue_x, red_x into the new back bank.
  - Go to CHECK.
  - If it arrives while busy: current fetch is aborted, the partially written bank's valid flag is cleared, then swap/latch/restart as above. Abort takes priority over any in-flight ROM return.
- FSM states: IDLE -> CHECK -> FETCH_B -> DRAIN_B -> FETCH_R -> DRAIN_R -> IDLE.
- CHECK (1 cycle):
  - row_b = next_y - blue_y, computed Y_W bits unsigned; a wrap gives a large value.
  - hit_b = (row_b < SPR_H). Same for red.
- FETCH_x:
  - Issue rom_req with col 0..SPR_W-1 on consecutive cycles; rom_row = row_x[4:0].
  - Skipped, with valid_x cleared, if hit_x = 0.
- DRAIN_x: 1 cycle capturing the last return. Each return is written to back[x][col] one cycle after its request. valid_x is set on the final write.
- Worst-case line fetch: 1 + 2*(SPR_W+1) = 39 cycles. busy low exactly when IDLE.
- rom_req is never asserted in IDLE or CHECK; rom_sel is constant within a FETCH state.
- Pixel path, 1-cycle latency from draw_x:
  - dx = draw_x - front_x, X_W unsigned.
  - A sprite is a candidate if front valid, dx < SPR_W, and idx != 0.
  - Red beats blue on overlap.
  - With no candidate: pix_hit = 0, pix_idx = 0, pix_sel = 0.
- Boundaries:
  - Tank partly above screen (y > next_y): no hit.
  - Tank near right edge: dx wraps naturally and only in-range columns hit.
  - Last sprite row (row 24) fetched; row 25 not.

Optional Feature:
- Macro SPRITE_FLIP_EN.
- Defined: adds inputs blue_flip and red_flip (1 bit each), sampled at line_start. When the latched flip is set, rom_col = SPR_W-1-col while the buffer index stays col, giving a horizontally mirrored row.
- Undefined: no flip ports; rom_col = col.

Decomposition:
- Package sprite_pkg holds:
  - SPR_W, SPR_H, IDX_W
  - enum spr_id_t {SPR_BLUE = 0, SPR_RED = 1}
  - enum fetch_state_t {IDLE, CHECK, FETCH_B, DRAIN_B, FETCH_R, DRAIN_R}
  - typedef spr_row_t = [0:SPR_W-1][IDX_W-1:0]
- One sub-module, sprite_row_buffer, instantiated per sprite. It owns the two banks, valid flags, latched x, bank-select toggle, write port and combinational read port.

Test Plan:
- Reset: reset_n low mid-FETCH_B -> all outputs 0 and busy = 0 immediately; after release, pix_hit stays 0 for any draw_x.
- Single hit: blue at (100,200), red at (400,400), line_start with next_y = 203 -> 18 reqs with rom_sel = 0, rom_row = 3, cols 0..17; no red reqs; busy high 21 cycles. After next line_start, draw_x = 108 returns the blue row-3 col-8 index one cycle later.
- Overlap: both tanks at (50,60), next_y = 60, ROM returns nonzero for both -> at draw_x = 52, pix_sel = 1 and pix_idx = red data. Where red idx = 0 and blue != 0 -> pix_sel = 0, blue data.
- Edges: blue_y = 10, next_y = 9 -> no fetch (wrap). next_y = 34 -> row 24 fetched. next_y = 35 -> no fetch. draw_x = 117 hits, draw_x = 118 misses for x = 100.
- Abort: second line_start 10 cycles into FETCH_B -> ROM reqs restart at col 0 in the next fetch; the aborted bank has valid = 0, so no pix_hit on that line.
- SPRITE_FLIP_EN: blue_flip = 1 -> rom_col sequence 17..0; draw_x = 100 shows the data returned for rom_col = 17.
